// File: rtl/npu_mem_pkg.sv
// Shared wide-RAM constants and the enums used by the wide-RAM arbiter.
package npu_mem_pkg;

    localparam int WRAM_DATA_W   = 1048;
    localparam int WRAM_LAST_ROW = 1024;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_NET  = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_N = 2'd2
    } arb_state_e;

    // One in-flight access: who issued it, whether it returns data, whether it faulted.
    typedef struct packed {
        logic    valid;
        logic    rd;
        logic    err;
        req_id_e owner;
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way tie breaker: grants the requester not served last.
// WRAM_ARB_CORE_PRIO_EN makes the core win every tie instead.
module rr_arb2
    import npu_mem_pkg::*;
(
    input  logic    [1:0] req_i,   // [0] core, [1] network
    input  req_id_e       last_i,
    output logic    [1:0] gnt_o
);

`ifdef WRAM_ARB_CORE_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
`ifdef WRAM_ARB_CORE_PRIO_EN
            gnt_o = 2'b01;
`else
            gnt_o = (last_i == REQ_NET) ? 2'b01 : 2'b10;
`endif
        end
    end

endmodule

// File: rtl/wram_arbiter.sv
// Core / network-DMA arbiter in front of a wide RAM, with lock bursts and a 2-deep read return pipe.
// WRAM_ARB_CORE_PRIO_EN selects fixed core priority on ties (default: round-robin).
module wram_arbiter
    import npu_mem_pkg::*;
#(
    parameter int DATA_W   = WRAM_DATA_W,
    parameter int LAST_ROW = WRAM_LAST_ROW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [31:0]       c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic              c_err,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              n_req,
    input  logic              n_we,
    input  logic              n_lock,
    input  logic [31:0]       n_addr,
    input  logic [DATA_W-1:0] n_wdata,
    output logic              n_gnt,
    output logic              n_rvalid,
    output logic              n_err,
    output logic [DATA_W-1:0] n_rdata,
    output logic [31:0]       ram_addr,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_menable,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_e        state_q, state_d;
    req_id_e           last_q, last_d;
    logic              rdy_q;
    logic [1:0]        rr_gnt, gnt;
    logic              acc_c, acc_n, accept;
    req_id_e           acc_id;
    logic              sel_we, sel_lock, in_range;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    tag_t              tag_d;
    tag_t              tag_q [2];
    logic              ret_rd;
    logic [31:0]       ram_addr_q;
    logic [DATA_W-1:0] ram_d_q, c_rdata_q, n_rdata_q;
    logic              ram_menable_q;

    rr_arb2 u_rr_arb2 (
        .req_i  ({n_req, c_req}),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    // rdy_q keeps grants off during the first edge after reset release.
    always_comb begin
        gnt = 2'b00;
        if (rdy_q) begin
            case (state_q)
                IDLE:    gnt = rr_gnt;
                OWN_C:   gnt = {1'b0, c_req};
                OWN_N:   gnt = {n_req, 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    assign c_gnt  = gnt[0];
    assign n_gnt  = gnt[1];
    assign acc_c  = c_req & gnt[0];
    assign acc_n  = n_req & gnt[1];
    assign accept = acc_c | acc_n;
    assign acc_id = acc_n ? REQ_NET : REQ_CORE;

    assign sel_we    = acc_n ? n_we    : c_we;
    assign sel_lock  = acc_n ? n_lock  : c_lock;
    assign sel_addr  = acc_n ? n_addr  : c_addr;
    assign sel_wdata = acc_n ? n_wdata : c_wdata;
    assign in_range  = (sel_addr <= 32'(LAST_ROW));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (accept) begin
            last_d = acc_id;
        end
        case (state_q)
            IDLE: begin
                if (accept && sel_lock) begin
                    state_d = acc_n ? OWN_N : OWN_C;
                end
            end
            OWN_C: begin
                if (!c_req || (acc_c && !c_lock)) begin
                    state_d = IDLE;
                end
            end
            OWN_N: begin
                if (!n_req || (acc_n && !n_lock)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_d       = '0;
        tag_d.valid = accept;
        tag_d.rd    = ~sel_we;
        tag_d.err   = ~in_range;
        tag_d.owner = acc_id;
    end

    // Stage 0 is aligned with the RAM read; ram_q is valid at the next edge.
    assign ret_rd = tag_q[0].valid & tag_q[0].rd & ~tag_q[0].err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= REQ_NET;
            rdy_q         <= 1'b0;
            ram_addr_q    <= '0;
            ram_d_q       <= '0;
            ram_menable_q <= 1'b0;
            tag_q[0]      <= '0;
            tag_q[1]      <= '0;
            c_rdata_q     <= '0;
            n_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            rdy_q         <= 1'b1;
            ram_menable_q <= accept & sel_we & in_range;
            if (accept) begin
                ram_addr_q <= sel_addr;
                ram_d_q    <= sel_wdata;
            end
            tag_q[0] <= tag_d;
            tag_q[1] <= tag_q[0];
            if (ret_rd && tag_q[0].owner == REQ_CORE) begin
                c_rdata_q <= ram_q;
            end
            if (ret_rd && tag_q[0].owner == REQ_NET) begin
                n_rdata_q <= ram_q;
            end
        end
    end

    assign c_rvalid = tag_q[1].valid & tag_q[1].rd & ~tag_q[1].err & (tag_q[1].owner == REQ_CORE);
    assign n_rvalid = tag_q[1].valid & tag_q[1].rd & ~tag_q[1].err & (tag_q[1].owner == REQ_NET);
    assign c_err    = tag_q[1].valid & tag_q[1].err & (tag_q[1].owner == REQ_CORE);
    assign n_err    = tag_q[1].valid & tag_q[1].err & (tag_q[1].owner == REQ_NET);

    assign c_rdata     = c_rdata_q;
    assign n_rdata     = n_rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_d       = ram_d_q;
    assign ram_menable = ram_menable_q;

endmodule

// File: tb/tb_wram_arbiter.sv
// Self-checking bench for wram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration and return rules.
module tb_wram_arbiter;
    import npu_mem_pkg::*;

    localparam int DW       = WRAM_DATA_W;
    localparam int LR       = WRAM_LAST_ROW;
    localparam int MEM_ROWS = 2048;
    localparam int NW       = (DW + 31) / 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
    logic [31:0]   c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          n_req = 1'b0, n_we = 1'b0, n_lock = 1'b0;
    logic [31:0]   n_addr = '0;
    logic [DW-1:0] n_wdata = '0;
    logic          c_gnt, c_rvalid, c_err, n_gnt, n_rvalid, n_err;
    logic [DW-1:0] c_rdata, n_rdata;
    logic [31:0]   ram_addr;
    logic [DW-1:0] ram_d;
    logic          ram_menable;
    logic [DW-1:0] ram_q;

    wram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
        .n_req(n_req), .n_we(n_we), .n_lock(n_lock), .n_addr(n_addr), .n_wdata(n_wdata),
        .n_gnt(n_gnt), .n_rvalid(n_rvalid), .n_err(n_err), .n_rdata(n_rdata),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_menable(ram_menable), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_row(input int unsigned a);
        logic [NW*32-1:0] t;
        for (int w = 0; w < NW; w++) t[w*32 +: 32] = a * 32'h9E37_79B1 + w * 32'h7F4A_7C15 + 32'h1234;
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [NW*32-1:0] t;
        for (int w = 0; w < NW; w++) t[w*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    // RAM environment: updates ram_q on the falling edge.
    logic [DW-1:0] ram_mem [MEM_ROWS];
    bit            ram_wr  [MEM_ROWS];
    always @(negedge clk) begin
        if (ram_menable && ram_addr < 32'(MEM_ROWS)) begin
            ram_mem[ram_addr[10:0]] <= ram_d;
            ram_wr[ram_addr[10:0]]  <= 1'b1;
        end
        if (ram_addr < 32'(MEM_ROWS))
            ram_q <= ram_wr[ram_addr[10:0]] ? ram_mem[ram_addr[10:0]] : init_row(ram_addr);
        else
            ram_q <= '0;
    end

    // Reference model state
    int            m_owner;   // 0 nobody, 1 core, 2 network
    int            m_last;    // 0 core, 1 network
    bit            m_ready;
    logic [DW-1:0] mem_model [MEM_ROWS];
    bit            p_valid, p_read, p_err;
    int            p_who;
    logic [DW-1:0] p_data;
    bit            e_c_gnt, e_n_gnt, e_c_rvalid, e_n_rvalid, e_c_err, e_n_err, e_menable;
    logic [31:0]   e_addr;
    logic [DW-1:0] e_d, e_c_rdata, e_n_rdata;
    logic          o_c_gnt, o_n_gnt;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    function void model_reset();
        m_owner = 0; m_last = 1; m_ready = 0; p_valid = 0;
        e_c_rvalid = 0; e_n_rvalid = 0; e_c_err = 0; e_n_err = 0; e_menable = 0;
        e_addr = '0; e_d = '0; e_c_rdata = '0; e_n_rdata = '0;
    endfunction

    function void model_grant();
        e_c_gnt = 0; e_n_gnt = 0;
        if (rst_n && m_ready) begin
            if (m_owner == 1) e_c_gnt = c_req;
            else if (m_owner == 2) e_n_gnt = n_req;
            else if (c_req && n_req) begin
`ifdef WRAM_ARB_CORE_PRIO_EN
                e_c_gnt = 1;
`else
                if (m_last == 1) e_c_gnt = 1; else e_n_gnt = 1;
`endif
            end else begin
                e_c_gnt = c_req; e_n_gnt = n_req;
            end
        end
    endfunction

    // Advance one clock; leaves time at posedge+1 with the model updated.
    task automatic tick();
        bit acc_c, acc_n;
        int who, own_prev;
        logic we, lock;
        logic [31:0] a;
        logic [DW-1:0] wd;
        who = 0; lock = 0;
        #1;
        model_grant();
        o_c_gnt = c_gnt; o_n_gnt = n_gnt;
        acc_c = c_req && e_c_gnt;
        acc_n = n_req && e_n_gnt;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (!m_ready) begin
            m_ready = 1;
            e_c_rvalid = 0; e_n_rvalid = 0; e_c_err = 0; e_n_err = 0; e_menable = 0;
        end else begin
            e_c_rvalid = 0; e_n_rvalid = 0; e_c_err = 0; e_n_err = 0; e_menable = 0;
            if (p_valid) begin
                if (p_err) begin
                    if (p_who == 1) e_c_err = 1; else e_n_err = 1;
                end else if (p_read) begin
                    if (p_who == 1) begin e_c_rvalid = 1; e_c_rdata = p_data; end
                    else begin e_n_rvalid = 1; e_n_rdata = p_data; end
                end
            end
            p_valid = 0;
            own_prev = m_owner;
            if (acc_c || acc_n) begin
                who  = acc_c ? 1 : 2;
                we   = acc_c ? c_we : n_we;
                lock = acc_c ? c_lock : n_lock;
                a    = acc_c ? c_addr : n_addr;
                wd   = acc_c ? c_wdata : n_wdata;
                e_addr = a; e_d = wd;
                e_menable = we && (a <= 32'(LR));
                p_valid = 1; p_who = who; p_read = !we; p_err = (a > 32'(LR));
                p_data = (a < 32'(MEM_ROWS)) ? mem_model[a[10:0]] : '0;
                if (we && a <= 32'(LR)) mem_model[a[10:0]] = wd;
                m_last = who - 1;
                $display("[%0d] accept %s %s row %0d%s", cyc, (who == 1) ? "core" : "net",
                         we ? "WR" : "RD", a, (a > 32'(LR)) ? " out-of-range" : "");
            end
            if (own_prev == 0) begin
                if (who != 0 && lock) m_owner = who;
            end else if (own_prev == 1) begin
                if (!c_req || (acc_c && !c_lock)) m_owner = 0;
            end else begin
                if (!n_req || (acc_n && !n_lock)) m_owner = 0;
            end
        end
        #1;
    endtask

    task automatic drain(input int n);
        c_req = 0; n_req = 0; c_lock = 0; n_lock = 0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 0; model_reset();
        c_req = 1; n_req = 1; c_addr = 32'd7; n_addr = 32'd8;
        #2;
        checks++; if (c_gnt !== 1'b0 || n_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b exp 00", c_gnt, n_gnt); end
        repeat (2) tick();
        checks++; if (ram_menable !== 1'b0 || ram_addr !== 32'd0 || ram_d !== '0) begin errors++; $display("FAIL reset_ram: menable %b addr %0d", ram_menable, ram_addr); end
        checks++; if (c_rdata !== '0 || n_rdata !== '0 || c_rvalid !== 1'b0 || n_err !== 1'b0) begin errors++; $display("FAIL reset_ret: rvalid %b err %b", c_rvalid, n_err); end
        rst_n = 1;
        tick();
        checks++; if (o_c_gnt !== 1'b0 || o_n_gnt !== 1'b0) begin errors++; $display("FAIL first_edge_gnt: got %b%b exp 00", o_c_gnt, o_n_gnt); end
        checks++; if (ram_addr !== 32'd0) begin errors++; $display("FAIL first_edge_accept: ram_addr %0d exp 0", ram_addr); end
        tick();
        checks++; if (o_c_gnt !== 1'b1 || o_n_gnt !== 1'b0) begin errors++; $display("FAIL first_tie: got c%b n%b exp c1 n0", o_c_gnt, o_n_gnt); end
        drain(3);
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        d = rand_data(); d[7:0] = 8'hAB;
        c_req = 1; c_we = 1; c_lock = 0; c_addr = 32'd5; c_wdata = d;
        tick();
        checks++; if (ram_menable !== 1'b1 || ram_addr !== 32'd5 || ram_d !== d) begin errors++; $display("FAIL wr_ram: menable %b addr %0d", ram_menable, ram_addr); end
        c_we = 0;
        tick();
        checks++; if (o_c_gnt !== 1'b1 || ram_menable !== 1'b0) begin errors++; $display("FAIL rd_accept: gnt %b menable %b", o_c_gnt, ram_menable); end
        c_req = 0;
        tick();
        checks++; if (c_rvalid !== 1'b1 || c_rdata !== d) begin errors++; $display("FAIL rd_data: rvalid %b data %h exp %h", c_rvalid, c_rdata[63:0], d[63:0]); end
        tick();
        checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: rvalid %b exp 0", c_rvalid); end
        drain(2);
    endtask

    task automatic test_contention();
        bit exp_c;
        n_req = 1; n_we = 0; n_lock = 0; n_addr = 32'd11;
        tick();
        c_req = 1; c_we = 0; c_lock = 0; c_addr = 32'd20;
        n_addr = 32'd30;
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef WRAM_ARB_CORE_PRIO_EN
            exp_c = 1;
`else
            exp_c = (i % 2 == 0);
`endif
            checks++; if (o_c_gnt !== exp_c || o_n_gnt !== !exp_c) begin errors++; $display("FAIL contention_%0d: got c%b n%b exp c%b", i, o_c_gnt, o_n_gnt, exp_c); end
            checks++; if (c_rvalid !== e_c_rvalid || n_rvalid !== e_n_rvalid) begin errors++; $display("FAIL contention_rv_%0d: got %b%b exp %b%b", i, c_rvalid, n_rvalid, e_c_rvalid, e_n_rvalid); end
            if (o_c_gnt) c_addr = c_addr + 1;
            if (o_n_gnt) n_addr = n_addr + 1;
        end
        drain(3);
    endtask

    task automatic test_burst_lock();
        int rows_seen;
        rows_seen = 0;
        n_req = 1; n_we = 0;
        for (int i = 0; i < 4; i++) begin
            n_addr = 32'(i); n_lock = (i < 3);
            if (i == 1) begin c_req = 1; c_we = 0; c_lock = 0; c_addr = 32'd9; end
            tick();
            checks++; if (o_n_gnt !== 1'b1 || o_c_gnt !== 1'b0) begin errors++; $display("FAIL burst_gnt_%0d: got c%b n%b exp n", i, o_c_gnt, o_n_gnt); end
            if (n_rvalid) begin
                checks++; if (n_rdata !== mem_model[rows_seen]) begin errors++; $display("FAIL burst_row_%0d: got %h", rows_seen, n_rdata[63:0]); end
                rows_seen++;
            end
        end
        n_req = 0; n_lock = 0;
        tick();
        checks++; if (o_c_gnt !== 1'b1) begin errors++; $display("FAIL burst_release: core gnt %b exp 1", o_c_gnt); end
        c_req = 0;
        for (int i = 0; i < 3; i++) begin
            if (n_rvalid) begin
                checks++; if (n_rdata !== mem_model[rows_seen]) begin errors++; $display("FAIL burst_row_%0d: got %h", rows_seen, n_rdata[63:0]); end
                rows_seen++;
            end
            tick();
        end
        checks++; if (rows_seen != 4) begin errors++; $display("FAIL burst_count: got %0d rvalid exp 4", rows_seen); end
        drain(2);
    endtask

    task automatic test_out_of_range();
        c_req = 1; c_we = 0; c_lock = 0; c_addr = 32'(LR + 1);
        tick();
        checks++; if (ram_menable !== 1'b0 || ram_addr !== 32'(LR + 1)) begin errors++; $display("FAIL oor_ram: menable %b addr %0d", ram_menable, ram_addr); end
        c_req = 0;
        tick();
        checks++; if (c_err !== 1'b1 || c_rvalid !== 1'b0 || n_err !== 1'b0) begin errors++; $display("FAIL oor_err: err %b rvalid %b exp 1 0", c_err, c_rvalid); end
        checks++; if (c_rdata !== e_c_rdata) begin errors++; $display("FAIL oor_hold: rdata %h", c_rdata[63:0]); end
        tick();
        checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL oor_pulse: err %b exp 0", c_err); end
        c_req = 1; c_we = 1; c_addr = 32'(LR + 1); c_wdata = rand_data();
        tick();
        checks++; if (ram_menable !== 1'b0) begin errors++; $display("FAIL oor_write: menable %b exp 0", ram_menable); end
        c_we = 0; c_addr = 32'(LR);
        tick();
        c_req = 0;
        tick();
        checks++; if (c_rvalid !== 1'b1 || c_err !== 1'b0 || c_rdata !== mem_model[LR]) begin errors++; $display("FAIL last_row: rvalid %b err %b data %h", c_rvalid, c_err, c_rdata[63:0]); end
        drain(2);
    endtask

    task automatic test_reset_mid_read();
        int bad;
        bad = 0;
        c_req = 1; c_we = 0; c_lock = 0; c_addr = 32'd3;
        tick();
        c_req = 1; n_req = 1; c_addr = 32'd4;
        #2; rst_n = 0; model_reset();
        #1;
        checks++; if (c_gnt !== 1'b0 || n_gnt !== 1'b0 || c_rvalid !== 1'b0 || c_err !== 1'b0 || ram_menable !== 1'b0) begin errors++; $display("FAIL midrst_outs: gnt %b%b rvalid %b", c_gnt, n_gnt, c_rvalid); end
        checks++; if (ram_addr !== 32'd0 || ram_d !== '0 || c_rdata !== '0 || n_rdata !== '0) begin errors++; $display("FAIL midrst_data: ram_addr %0d", ram_addr); end
        repeat (3) begin
            tick();
            if (c_rvalid || c_err || n_rvalid || n_err) bad++;
        end
        rst_n = 1;
        tick();
        if (c_rvalid || c_err || n_rvalid || n_err) bad++;
        checks++; if (o_c_gnt !== 1'b0 || o_n_gnt !== 1'b0) begin errors++; $display("FAIL midrst_first_edge: gnt %b%b exp 00", o_c_gnt, o_n_gnt); end
        tick();
        if (c_rvalid || c_err || n_rvalid || n_err) bad++;
        checks++; if (o_c_gnt !== 1'b1 || o_n_gnt !== 1'b0) begin errors++; $display("FAIL midrst_tie: got c%b n%b exp c1 n0", o_c_gnt, o_n_gnt); end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_stale: %0d stale returns exp 0", bad); end
        drain(3);
    endtask

    task automatic test_random(input int n);
        bit c_pend, n_pend;
        c_pend = 0; n_pend = 0;
        for (int i = 0; i < n; i++) begin
            if (!c_pend) begin
                c_req = ($urandom_range(0, 99) < 60);
                c_pend = c_req;
                c_we = ($urandom_range(0, 99) < 40); c_lock = ($urandom_range(0, 99) < 30);
                c_addr = $urandom_range(0, LR + 40); c_wdata = rand_data();
            end
            if (!n_pend) begin
                n_req = ($urandom_range(0, 99) < 60);
                n_pend = n_req;
                n_we = ($urandom_range(0, 99) < 40); n_lock = ($urandom_range(0, 99) < 30);
                n_addr = $urandom_range(0, LR + 40); n_wdata = rand_data();
            end
            tick();
            if (c_req && e_c_gnt) c_pend = 0;
            if (n_req && e_n_gnt) n_pend = 0;
            checks++; if (o_c_gnt !== e_c_gnt || o_n_gnt !== e_n_gnt) begin errors++; $display("FAIL rand_gnt cyc %0d: got %b%b exp %b%b", cyc, o_c_gnt, o_n_gnt, e_c_gnt, e_n_gnt); end
            checks++; if (c_rvalid !== e_c_rvalid || n_rvalid !== e_n_rvalid) begin errors++; $display("FAIL rand_rvalid cyc %0d: got %b%b exp %b%b", cyc, c_rvalid, n_rvalid, e_c_rvalid, e_n_rvalid); end
            checks++; if (c_err !== e_c_err || n_err !== e_n_err) begin errors++; $display("FAIL rand_err cyc %0d: got %b%b exp %b%b", cyc, c_err, n_err, e_c_err, e_n_err); end
            checks++; if (c_rdata !== e_c_rdata) begin errors++; $display("FAIL rand_c_rdata cyc %0d: got %h exp %h", cyc, c_rdata[63:0], e_c_rdata[63:0]); end
            checks++; if (n_rdata !== e_n_rdata) begin errors++; $display("FAIL rand_n_rdata cyc %0d: got %h exp %h", cyc, n_rdata[63:0], e_n_rdata[63:0]); end
            checks++; if (ram_menable !== e_menable || ram_addr !== e_addr) begin errors++; $display("FAIL rand_ram cyc %0d: menable %b addr %0d exp %b %0d", cyc, ram_menable, ram_addr, e_menable, e_addr); end
            checks++; if (ram_d !== e_d) begin errors++; $display("FAIL rand_ram_d cyc %0d: got %h exp %h", cyc, ram_d[63:0], e_d[63:0]); end
        end
        drain(3);
    endtask

    initial begin
        for (int i = 0; i < MEM_ROWS; i++) mem_model[i] = init_row(i);
        model_reset();
        test_reset();
        test_write_read();
        test_contention();
        test_burst_lock();
        test_out_of_range();
        test_reset_mid_read();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
